i2s_transmitter: RTL and testbench
==================================

I2S_TRANSMITTER -- requirements
Module: i2s_transmitter

Interface
REQ-001 Parameter: WIDTH, 16, bits per channel sample (legal 8..32).
REQ-002 clk  input  1  system clock; all logic on rising edge.
REQ-003 rst  input  1  synchronous reset, active high.
REQ-004 clk_en  input  1  bit-rate enable pulse from clock_generator (e.g. clk_en_4); one clk wide; continuous high also legal.
REQ-005 sample_left  input  WIDTH  left-channel sample, two's complement.
REQ-006 sample_right  input  WIDTH  right-channel sample, two's complement.
REQ-007 sample_valid  input  1  sample pair present on sample_left/right.
REQ-008 sample_ready  output  1  holding register empty; pair accepted when valid and ready are both 1 on a rising clk edge.
REQ-009 i2s_bclk  output  1  bit clock, registered.
REQ-010 i2s_lrclk  output  1  word select, registered; 0 = left, 1 = right.
REQ-011 i2s_sdata  output  1  serial data, registered, MSB first.
REQ-012 underrun  output  1  one-clk pulse when a frame starts with no sample pending.

Function
REQ-013 The block SHALL hold a one-entry holding register (2*WIDTH bits plus full flag) and a 2*WIDTH-bit frame shift register {left, right}.
REQ-014 sample_ready SHALL equal NOT full; an accept SHALL set full on the same edge and capture both channels.
REQ-015 Bit counter k SHALL range 0..2*WIDTH-1 and wrap from 2*WIDTH-1 to 0.
REQ-016 On a clk_en cycle with i2s_bclk = 0, the block SHALL set i2s_bclk to 1 and change nothing else (rising edge; receiver samples).
REQ-017 On a clk_en cycle with i2s_bclk = 1 (falling edge), the block SHALL set i2s_bclk to 0, advance k, and update i2s_sdata and i2s_lrclk for the new k.
REQ-018 Cycles without clk_en SHALL leave i2s_bclk, i2s_lrclk, i2s_sdata, k and the shift register unchanged.
REQ-019 At the falling edge where k becomes 0 (frame start), the block SHALL load the shift register from the holding register if full and clear full; otherwise it SHALL load all zeros and pulse underrun for exactly one clk.
REQ-020 At falling edge k, i2s_sdata SHALL equal frame bit [2*WIDTH-1-k]; for k = 0 this is the MSB of the frame just loaded.
REQ-021 At falling edge k, i2s_lrclk SHALL be 1 for WIDTH-1 <= k <= 2*WIDTH-2 and 0 otherwise, so it changes one bclk before each channel MSB (standard I2S one-bit delay).
REQ-022 A frame load and an accept in the same clk SHALL be ordered as follows: the load uses the holding contents from before that edge. Since ready was 0 when full, a simultaneous load and accept occurs only when the holding register was empty. In that case the load inserts zeros and raises underrun, and the new pair remains in the holding register for the next frame; there is no bypass.
REQ-023 When the holding register is full and a frame load occurs, sample_ready SHALL rise on the following clk.
REQ-024 Latency: a pair accepted while the holding register is empty SHALL appear on i2s_sdata starting at the next frame start.
REQ-025 Frame period SHALL be 2*WIDTH bclk periods, i.e. 4*WIDTH clk_en pulses.

Reset
REQ-026 While rst = 1, the block SHALL set i2s_bclk = 0, i2s_lrclk = 0, i2s_sdata = 0, underrun = 0, full = 0 (sample_ready = 1), k = 2*WIDTH-1 and the shift register to zeros.
REQ-027 rst SHALL override clk_en and sample_valid; a reset mid-frame SHALL abort the frame and discard the pending sample.
REQ-028 After rst deasserts, the first falling bclk edge SHALL be a frame start (k = 0).

Verification (WIDTH = 16, clk_en from clock_generator clk_en_4)
REQ-029 Reset: hold rst for 5 clks -> bclk/lrclk/sdata/underrun all 0, sample_ready = 1.
REQ-030 Single pair: left = 16'hA5C3 and right = 16'h0F01 accepted before the first falling edge -> the receiver reconstructs left while lrclk = 0 and right while lrclk = 1; lrclk toggles one bclk before each MSB; underrun stays 0.
REQ-031 Back-to-back frames: source always valid -> continuous frames with no underrun; ready deasserts after each accept and reasserts the clk after each frame load.
REQ-032 Underrun: no sample supplied -> sdata stays 0 for the whole frame and underrun pulses exactly once per frame start, each pulse one clk wide.
REQ-033 Simultaneous load and accept: assert valid on the exact clk of a frame start with the holding register empty -> underrun pulses, that frame is zero, and the pair plays in the following frame.
REQ-034 Reset mid-frame: assert rst at k = 20 -> outputs return to reset values; the next frame starts cleanly at k = 0 with a new sample.

Source files
------------

// File: rtl/i2s_transmitter.sv
`default_nettype none
// ============================================================================
//  Module      : i2s_transmitter
//  Description : Standard I2S serializer. A one-entry holding register takes
//                a {left, right} pair over a valid/ready handshake. At each
//                frame start the pair moves into a frame shift register and is
//                sent MSB first, with the one-bit word-select delay of I2S.
//                A missing sample plays a zero frame and pulses underrun.
//  Revision    : 1.0 - initial release
// ============================================================================
module i2s_transmitter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_en,
    input  logic [WIDTH-1:0] sample_left,
    input  logic [WIDTH-1:0] sample_right,
    input  logic             sample_valid,
    output logic             sample_ready,
    output logic             i2s_bclk,
    output logic             i2s_lrclk,
    output logic             i2s_sdata,
    output logic             underrun
);

    localparam int                 c_FRAME_W  = 2 * WIDTH;
    localparam int                 c_K_W      = $clog2(c_FRAME_W);
    localparam logic [c_K_W-1:0]   c_K_LAST   = c_K_W'(c_FRAME_W - 1);
    localparam logic [c_K_W-1:0]   c_K_LR_LO  = c_K_W'(WIDTH - 1);
    localparam logic [c_K_W-1:0]   c_K_LR_HI  = c_K_W'(c_FRAME_W - 2);

    logic [c_FRAME_W-1:0] r_hold_q,     w_hold_d;
    logic                 r_full_q,     w_full_d;
    logic [c_FRAME_W-1:0] r_shift_q,    w_shift_d;
    logic [c_K_W-1:0]     r_k_q,        w_k_d;
    logic                 r_bclk_q,     w_bclk_d;
    logic                 r_lrclk_q,    w_lrclk_d;
    logic                 r_sdata_q,    w_sdata_d;
    logic                 r_underrun_q, w_underrun_d;

    logic                 w_accept;
    logic [c_K_W-1:0]     w_k_next;

    // Next-state logic: bclk toggling, frame loading and the input handshake.
    // The frame load looks only at r_full_q, so an accept on the same edge
    // cannot bypass into the frame being loaded.
    always_comb begin
        w_hold_d     = r_hold_q;
        w_full_d     = r_full_q;
        w_shift_d    = r_shift_q;
        w_k_d        = r_k_q;
        w_bclk_d     = r_bclk_q;
        w_lrclk_d    = r_lrclk_q;
        w_sdata_d    = r_sdata_q;
        w_underrun_d = 1'b0;

        w_accept = sample_valid && !r_full_q;
        w_k_next = (r_k_q == c_K_LAST) ? '0 : r_k_q + c_K_W'(1);

        if (clk_en) begin
            if (!r_bclk_q) begin
                // Rising bclk: receiver samples, nothing else moves.
                w_bclk_d = 1'b1;
            end else begin
                w_bclk_d  = 1'b0;
                w_k_d     = w_k_next;
                // Word select leads each channel MSB by one bit.
                w_lrclk_d = (w_k_next >= c_K_LR_LO) && (w_k_next <= c_K_LR_HI);
                if (w_k_next == '0) begin
                    if (r_full_q) begin
                        w_shift_d = r_hold_q;
                        w_full_d  = 1'b0;
                    end else begin
                        w_shift_d    = '0;
                        w_underrun_d = 1'b1;
                    end
                end else begin
                    w_shift_d = {r_shift_q[c_FRAME_W-2:0], 1'b0};
                end
                w_sdata_d = w_shift_d[c_FRAME_W-1];
            end
        end

        if (w_accept) begin
            w_hold_d = {sample_left, sample_right};
            w_full_d = 1'b1;
        end
    end

    // State registers; reset parks k on the last bit so the first fall starts a frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold_q     <= '0;
            r_full_q     <= 1'b0;
            r_shift_q    <= '0;
            r_k_q        <= c_K_LAST;
            r_bclk_q     <= 1'b0;
            r_lrclk_q    <= 1'b0;
            r_sdata_q    <= 1'b0;
            r_underrun_q <= 1'b0;
        end else begin
            r_hold_q     <= w_hold_d;
            r_full_q     <= w_full_d;
            r_shift_q    <= w_shift_d;
            r_k_q        <= w_k_d;
            r_bclk_q     <= w_bclk_d;
            r_lrclk_q    <= w_lrclk_d;
            r_sdata_q    <= w_sdata_d;
            r_underrun_q <= w_underrun_d;
        end
    end

    assign sample_ready = ~r_full_q;
    assign i2s_bclk     = r_bclk_q;
    assign i2s_lrclk    = r_lrclk_q;
    assign i2s_sdata    = r_sdata_q;
    assign underrun     = r_underrun_q;

endmodule
`default_nettype wire

// File: tb/tb_i2s_transmitter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_i2s_transmitter
//  Description : Directed self-checking bench for i2s_transmitter (WIDTH=16)
//                with a divide-by-4 clk_en strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_i2s_transmitter;

    localparam int WIDTH = 16;

    logic             clk;
    logic             rst;
    logic             clk_en;
    logic [WIDTH-1:0] sample_left;
    logic [WIDTH-1:0] sample_right;
    logic             sample_valid;
    logic             sample_ready;
    logic             i2s_bclk;
    logic             i2s_lrclk;
    logic             i2s_sdata;
    logic             underrun;

    i2s_transmitter #(.WIDTH(WIDTH)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .clk_en       (clk_en),
        .sample_left  (sample_left),
        .sample_right (sample_right),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .i2s_bclk     (i2s_bclk),
        .i2s_lrclk    (i2s_lrclk),
        .i2s_sdata    (i2s_sdata),
        .underrun     (underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Source pair table (left, right)
    logic [15:0] c_pair_l [6] = '{16'hA5C3, 16'h1234, 16'hFFFF, 16'h7FFE, 16'hDEAD, 16'h5A5A};
    logic [15:0] c_pair_r [6] = '{16'h0F01, 16'h8001, 16'h0000, 16'hC3A5, 16'hBEEF, 16'h0FF0};

    int   n_checks = 0;
    int   n_errors = 0;
    int   und_cnt  = 0;
    int   idx      = 0;
    int   src_limit = 0;
    logic arm_sim  = 1'b0;
    logic drv_src  = 1'b0;
    logic prev_bclk = 1'b0;
    logic last_ready = 1'b0;
    logic fall     = 1'b0;
    logic [1:0] en_cnt = 2'd0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One clk step: sample at negedge, track handshake, drive clk_en and source.
    task automatic tick();
        @(negedge clk);
        fall      = prev_bclk && !i2s_bclk;
        prev_bclk = i2s_bclk;
        if (underrun) und_cnt++;
        if (drv_src && sample_valid && last_ready && !rst) idx++;
        last_ready = sample_ready;
        clk_en = (en_cnt == 2'd3);
        en_cnt = en_cnt + 2'd1;
        drv_src = 1'b0;
        if (idx < src_limit) begin
            sample_valid = 1'b1;
            sample_left  = c_pair_l[idx];
            sample_right = c_pair_r[idx];
            drv_src      = 1'b1;
        end else if (arm_sim && i2s_bclk && clk_en) begin
            sample_valid = 1'b1;
            sample_left  = 16'h8421;
            sample_right = 16'h7BDE;
            arm_sim      = 1'b0;
        end else begin
            sample_valid = 1'b0;
        end
    endtask

    // Capture one full frame (32 falling bclk edges starting at k=0) and check it.
    task automatic run_frame(input string tag, input logic [31:0] exp_frame, input int exp_und,
                             input logic exp_rdy_s, input logic exp_rdy_e);
        logic [31:0] rxf;
        logic [31:0] rxl;
        logic        rdy_s;
        int          nf;
        int          guard;
        rxf = '0; rxl = '0; rdy_s = 1'b0; nf = 0; guard = 0;
        und_cnt = 0;
        while (nf < 32 && guard < 400) begin
            tick();
            guard++;
            if (fall) begin
                if (nf == 0) rdy_s = sample_ready;
                rxf[31-nf] = i2s_sdata;
                rxl[31-nf] = i2s_lrclk;
                nf++;
            end
        end
        check({tag, "_bits"}, 32'(nf), 32'd32);
        check({tag, "_left"}, {16'h0, rxf[31:16]}, {16'h0, exp_frame[31:16]});
        check({tag, "_right"}, {16'h0, rxf[15:0]}, {16'h0, exp_frame[15:0]});
        check({tag, "_lrclk"}, rxl, 32'h0001_FFFE);
        check({tag, "_underrun"}, 32'(und_cnt), 32'(exp_und));
        check({tag, "_rdy_start"}, {31'h0, rdy_s}, {31'h0, exp_rdy_s});
        check({tag, "_rdy_end"}, {31'h0, sample_ready}, {31'h0, exp_rdy_e});
    endtask

    initial begin
        rst = 1'b1; clk_en = 1'b0; sample_valid = 1'b0;
        sample_left = '0; sample_right = '0;

        // Reset state
        repeat (5) tick();
        check("rst_bclk",  {31'h0, i2s_bclk},     32'h0);
        check("rst_lrclk", {31'h0, i2s_lrclk},    32'h0);
        check("rst_sdata", {31'h0, i2s_sdata},    32'h0);
        check("rst_und",   {31'h0, underrun},     32'h0);
        check("rst_ready", {31'h0, sample_ready}, 32'h1);

        // Single pair accepted before the first falling edge
        rst = 1'b0;
        src_limit = 1;
        run_frame("single", 32'hA5C3_0F01, 0, 1'b1, 1'b1);

        // Back-to-back frames with an always-valid source
        src_limit = 4;
        run_frame("b2b1", 32'h1234_8001, 0, 1'b1, 1'b0);
        run_frame("b2b2", 32'hFFFF_0000, 0, 1'b1, 1'b0);
        run_frame("b2b3", 32'h7FFE_C3A5, 0, 1'b1, 1'b1);

        // Underrun: no samples
        run_frame("und1", 32'h0, 1, 1'b1, 1'b1);
        run_frame("und2", 32'h0, 1, 1'b1, 1'b1);

        // Valid on the exact frame-start clk with holding empty
        arm_sim = 1'b1;
        run_frame("sim_zero", 32'h0, 1, 1'b0, 1'b0);
        run_frame("sim_play", 32'h8421_7BDE, 0, 1'b1, 1'b1);

        // Reset mid-frame at k=20 with a pending pair that must be discarded
        begin
            int nf;
            int guard;
            nf = 0; guard = 0;
            while (nf < 21 && guard < 400) begin
                tick();
                guard++;
                if (fall) nf++;
            end
            check("mid_reach_k20", 32'(nf), 32'd21);
            check("mid_lrclk_k20", {31'h0, i2s_lrclk}, 32'h1);
        end
        src_limit = 5;
        repeat (3) tick();
        check("mid_pending", {31'h0, sample_ready}, 32'h0);
        rst = 1'b1;
        repeat (3) tick();
        check("mid_rst_bclk",  {31'h0, i2s_bclk},     32'h0);
        check("mid_rst_lrclk", {31'h0, i2s_lrclk},    32'h0);
        check("mid_rst_sdata", {31'h0, i2s_sdata},    32'h0);
        check("mid_rst_und",   {31'h0, underrun},     32'h0);
        check("mid_rst_ready", {31'h0, sample_ready}, 32'h1);
        rst = 1'b0;
        src_limit = 6;
        run_frame("post_rst", 32'h5A5A_0FF0, 0, 1'b1, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
